// File: rtl/shift_issue_if.sv
// rtl/shift_issue_if.sv - request and result streams of the shift issue stage
interface shift_issue_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [4:0]   in_shamt;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - two-stage issue/capture wrapper around the external sra_module
// Optional completed-operation counter enabled by SHIFT_ISSUE_CNT_EN.
module shift_issue_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_issue_if.slave     bus,
    output logic [W-1:0]     sh_inp,
    output logic [4:0]       sh_sel,
    input  logic [W-1:0]     sh_out,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0]   OP_SRA  = 2'b00;
    localparam logic [1:0]   OP_SRL  = 2'b01;
    localparam logic [1:0]   OP_SLL  = 2'b10;
    localparam logic [1:0]   OP_PASS = 2'b11;
    localparam logic [W-1:0] ONES    = '1;

    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    logic         s1_valid;
    logic [W-1:0] s1_data;
    logic [4:0]   s1_shamt;
    logic [1:0]   s1_op;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic [W-1:0] result;
    logic         in_fire;
    logic         s2_load;

    assign bus.in_ready  = !s1_valid || !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign s2_load       = s1_valid && (!out_valid_q || bus.out_ready);

    // SLL reuses the arithmetic right shifter by mirroring the operand around it.
    always_comb begin
        sh_inp = '0;
        sh_sel = '0;
        if (s1_valid) begin
            sh_inp = (s1_op == OP_SLL) ? bit_rev(s1_data) : s1_data;
            sh_sel = (s1_op == OP_PASS) ? 5'd0 : s1_shamt;
        end
    end

    always_comb begin
        result = sh_out;
        case (s1_op)
            OP_SRA:  result = sh_out;
            OP_SRL:  result = sh_out & (ONES >> s1_shamt);
            OP_SLL:  result = bit_rev(sh_out) & (ONES << s1_shamt);
            default: result = s1_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_op    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= bus.in_data;
            s1_shamt <= bus.in_shamt;
            s1_op    <= bus.in_op;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (s2_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= result;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef SHIFT_ISSUE_CNT_EN
    logic             out_fire;
    logic [CNT_W-1:0] cnt_q;

    assign out_fire = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_fire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign op_count = cnt_q;
`else
    assign op_count = '0;
`endif
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - scoreboard bench for shift_issue_stage with an sra_module model
module tb_shift_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sh_inp;
    logic [31:0] sh_out;
    logic [4:0]  sh_sel;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    shift_issue_if #(.W(32)) bus();

    // Behaviour of the downstream combinational arithmetic right shifter.
    assign sh_out = 32'($signed(sh_inp) >>> sh_sel);

    shift_issue_stage #(.W(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sh_inp   (sh_inp),
        .sh_sel   (sh_sel),
        .sh_out   (sh_out),
        .op_count (op_count)
    );

    int          checks    = 0;
    int          errors    = 0;
    int          hs_count  = 0;
    int          acc_count = 0;
    logic [31:0] sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d,
                                               input logic [4:0] s);
        logic signed [31:0] sd;
        sd = d;
        case (op)
            2'b00:   return sd >>> s;
            2'b01:   return d >> s;
            2'b10:   return d << s;
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.in_valid && bus.in_ready) begin
            sbq.push_back(ref_result(bus.in_op, bus.in_data, bus.in_shamt));
            acc_count++;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected no output", bus.out_data);
            end else begin
                check("sb_data", bus.out_data, sbq.pop_front());
            end
            hs_count++;
        end
    end

    always @(negedge rst_n) begin
        sbq.delete();
        hs_count  = 0;
        acc_count = 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        int   n  = 0;
        logic ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = s;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
            n++;
        end while (!ok && n < 50);
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sbq.size() != 0 && n < limit) begin
            step();
            n++;
        end
        step();
        check("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        int          acc;
        logic [31:0] hold_inp;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_sh_inp", sh_inp, 0);
        check("rst_sh_sel", sh_sel, 0);
        check("rst_op_count", op_count, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        send(2'b00, 32'hFFFFFFFE, 5'd1);
        check("sra_sh_sel", sh_sel, 5'b00001);
        check("sra_sh_inp", sh_inp, 32'hFFFFFFFE);
        step();
        check("sra_out_valid", bus.out_valid, 1);
        check("sra_out_data", bus.out_data, 32'hFFFFFFFF);
        step();
        check("sra_pulse_end", bus.out_valid, 0);

        send(2'b01, 32'h80000000, 5'd31);
        step();
        check("srl31_data", bus.out_data, 32'h00000001);
        send(2'b00, 32'h80000000, 5'd31);
        step();
        check("sra31_data", bus.out_data, 32'hFFFFFFFF);

        send(2'b10, 32'h00000001, 5'd4);
        check("sll_sh_inp", sh_inp, 32'h80000000);
        check("sll_sh_sel", sh_sel, 5'b00100);
        step();
        check("sll_data", bus.out_data, 32'h00000010);
        send(2'b11, 32'hA5A5_1234, 5'd7);
        check("pass_sh_sel", sh_sel, 0);
        step();
        check("pass_data", bus.out_data, 32'hA5A5_1234);
        step();

        // Three back-to-back requests against a stalled consumer.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 2'b01;
            bus.in_data  = 32'hF000_0100 + 32'(i);
            bus.in_shamt = 5'(i + 1);
            @(negedge clk);
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", acc, 2);
        check("bp_in_ready", bus.in_ready, 0);
        hold_inp = sh_inp;
        step();
        step();
        check("bp_sh_inp_stable", sh_inp, hold_inp);
        check("bp_sh_sel_stable", sh_sel, 5'd2);
        check("bp_out_valid_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_valid0", bus.out_valid, 1);
        @(negedge clk);
        check("bp_rel_valid1", bus.out_valid, 1);
        @(negedge clk);
        check("bp_rel_valid2", bus.out_valid, 0);
        check("bp_sb_empty", sbq.size(), 0);
        step();

        // Fill both stages, then reset between clock edges.
        bus.out_ready = 1'b0;
        send(2'b00, 32'h8000_0000, 5'd3);
        send(2'b01, 32'h1234_5678, 5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_sh_sel", sh_sel, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", bus.out_valid, 0);
        end
        step();

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_op     = 2'($urandom % 4);
            bus.in_data   = $urandom;
            bus.in_shamt  = (($urandom % 5) == 0) ? 5'd0 : 5'($urandom % 32);
            bus.out_ready = ($urandom % 3) != 0;
            step();
        end
        drain(20);
`ifdef SHIFT_ISSUE_CNT_EN
        check("rand_op_count", op_count, 16'(hs_count));
`else
        check("rand_op_count", op_count, 0);
`endif

`ifdef SHIFT_ISSUE_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("wrap_start_count", op_count, 0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = 2'b11;
        bus.in_data   = 32'h0BAD_CAFE;
        bus.in_shamt  = 5'd0;
        for (int n = 0; n < 70000 && acc_count < 65537; n++) step();
        bus.in_valid = 1'b0;
        drain(20);
        check("wrap_handshakes", hs_count, 65537);
        check("wrap_op_count", op_count, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
